// File: rtl/draw_cmd_queue_pkg.sv
// ---------------------------------------------------------------------------
// draw_cmd_queue_pkg
// Shared definitions for the draw command queue and its FIFO:
//   - FSM state encodings (IDLE=0, ISSUE=1, WAIT=2)
//   - command field widths and the packed command width (CMD_W=20)
//   - default busy intervals for the box and full-screen sweeps, matching the
//     timing of the tumbler_vga drawing stage
//   - pack/unpack helpers for the command word
// ---------------------------------------------------------------------------
package draw_cmd_queue_pkg;

    localparam int X_W   = 8;
    localparam int Y_W   = 8;
    localparam int COL_W = 3;
    localparam int CMD_W = X_W + Y_W + COL_W + 1;

    // 4x4 box sweep and 160x120 full-screen sweep of the drawing stage
    localparam int DEF_BOX_CYCLES  = 16;
    localparam int DEF_FULL_CYCLES = 19200;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    typedef struct packed {
        logic [X_W-1:0]   x;
        logic [Y_W-1:0]   y;
        logic [COL_W-1:0] colour;
        logic             full;
    } draw_cmd_t;

    function automatic logic [CMD_W-1:0] pack_cmd(
        input logic [X_W-1:0]   x,
        input logic [Y_W-1:0]   y,
        input logic [COL_W-1:0] colour,
        input logic             full
    );
        return {x, y, colour, full};
    endfunction

    function automatic draw_cmd_t unpack_cmd(input logic [CMD_W-1:0] raw);
        return draw_cmd_t'(raw);
    endfunction

endpackage

// File: rtl/draw_cmd_fifo.sv
// ---------------------------------------------------------------------------
// draw_cmd_fifo
// Generic synchronous FIFO with asynchronous active-low reset.
//   clock, resetn    : clock, async active-low reset
//   push, wr_data    : write request and data (ignored while full)
//   pop              : read request (ignored while empty or during flush)
//   flush            : drop all stored entries; a same-edge push becomes the
//                      only entry
//   rd_data          : head entry (valid when !empty)
//   full, empty      : occupancy flags
//   level            : occupancy count, 0..DEPTH
// DEPTH must be a power of two and at least 2 so the pointers wrap naturally.
// ---------------------------------------------------------------------------
module draw_cmd_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 20
) (
    input  logic                     clock,
    input  logic                     resetn,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     pop,
    input  logic                     flush,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [LW-1:0]    count_r;
    logic             full_s;
    logic             empty_s;
    logic             push_ok_s;
    logic             pop_ok_s;

    // Occupancy flags and qualified push/pop requests
    always_comb begin
        full_s    = (count_r == LW'(DEPTH));
        empty_s   = (count_r == {LW{1'b0}});
        push_ok_s = push & ~full_s;
        pop_ok_s  = pop & ~empty_s & ~flush;
    end

    assign rd_data = mem_r[rd_ptr_r];
    assign full    = full_s;
    assign empty   = empty_s;
    assign level   = count_r;

    // Storage, pointers and occupancy count
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {LW{1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {WIDTH{1'b0}};
            end
        end else if (flush) begin
            // Restart from slot 0 so a coalesced entry becomes the head
            rd_ptr_r <= {AW{1'b0}};
            if (push_ok_s) begin
                mem_r[0] <= wr_data;
                wr_ptr_r <= AW'(1);
                count_r  <= LW'(1);
            end else begin
                wr_ptr_r <= {AW{1'b0}};
                count_r  <= {LW{1'b0}};
            end
        end else begin
            if (push_ok_s) begin
                mem_r[wr_ptr_r] <= wr_data;
                wr_ptr_r        <= wr_ptr_r + AW'(1);
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + LW'(1);
                2'b01:   count_r <= count_r - LW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/draw_cmd_queue.sv
// ---------------------------------------------------------------------------
// draw_cmd_queue
// Buffers draw commands from the code translator and paces their issue to the
// VGA drawing stage: one command per completed draw, each issued with a
// single-cycle out_draw strobe followed by a fixed busy interval
// (BOX_CYCLES for a small box, FULL_CYCLES for a full-screen box).
//
// Ports:
//   clock, resetn          : clock, async active-low reset
//   in_valid / in_ready    : command handshake (in_ready = queue not full)
//   in_x, in_y, in_colour, in_full : command fields
//   out_x, out_y, out_colour, out_full : issued command, held until next issue
//   out_draw               : one-cycle strobe per issued command
//   busy                   : high while a command is issuing or waiting
//   level                  : queue occupancy
//
// Optional build macro DRAW_QUEUE_COALESCE_EN: accepting a full-screen command
// discards every queued, not-yet-issued entry so the full command is next.
// ---------------------------------------------------------------------------
module draw_cmd_queue
    import draw_cmd_queue_pkg::*;
#(
    parameter int DEPTH       = 8,
    parameter int BOX_CYCLES  = DEF_BOX_CYCLES,
    parameter int FULL_CYCLES = DEF_FULL_CYCLES,
    parameter int CNT_W       = 15
) (
    input  logic                   clock,
    input  logic                   resetn,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [X_W-1:0]         in_x,
    input  logic [Y_W-1:0]         in_y,
    input  logic [COL_W-1:0]       in_colour,
    input  logic                   in_full,
    output logic [X_W-1:0]         out_x,
    output logic [Y_W-1:0]         out_y,
    output logic [COL_W-1:0]       out_colour,
    output logic                   out_full,
    output logic                   out_draw,
    output logic                   busy,
    output logic [$clog2(DEPTH):0] level
);

    logic [CMD_W-1:0] wr_data_s;
    logic [CMD_W-1:0] rd_data_s;
    draw_cmd_t        head_s;
    logic             fifo_full_s;
    logic             fifo_empty_s;
    logic             push_s;
    logic             pop_s;
    logic             flush_s;
    logic [CNT_W-1:0] load_s;

    state_t           state_r;
    logic [CNT_W-1:0] cnt_r;
    logic [X_W-1:0]   out_x_r;
    logic [Y_W-1:0]   out_y_r;
    logic [COL_W-1:0] out_colour_r;
    logic             out_full_r;
    logic             out_draw_r;
    logic             busy_r;

    // Handshake, head decode, pop decision and interval selection
    always_comb begin
        wr_data_s = pack_cmd(in_x, in_y, in_colour, in_full);
        head_s    = unpack_cmd(rd_data_s);
        push_s    = in_valid & ~fifo_full_s;
`ifdef DRAW_QUEUE_COALESCE_EN
        flush_s   = push_s & in_full;
`else
        flush_s   = 1'b0;
`endif
        // A flushing push replaces the head, so the old head must not issue
        pop_s     = (state_r == ST_IDLE) & ~fifo_empty_s & ~flush_s;
        if (head_s.full) begin
            load_s = CNT_W'(FULL_CYCLES);
        end else begin
            load_s = CNT_W'(BOX_CYCLES);
        end
    end

    draw_cmd_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (CMD_W)
    ) u_fifo (
        .clock   (clock),
        .resetn  (resetn),
        .push    (push_s),
        .wr_data (wr_data_s),
        .pop     (pop_s),
        .flush   (flush_s),
        .rd_data (rd_data_s),
        .full    (fifo_full_s),
        .empty   (fifo_empty_s),
        .level   (level)
    );

    // Issue FSM: busy counter, draw strobe and held output command
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_r      <= ST_IDLE;
            cnt_r        <= {CNT_W{1'b0}};
            out_x_r      <= {X_W{1'b0}};
            out_y_r      <= {Y_W{1'b0}};
            out_colour_r <= {COL_W{1'b0}};
            out_full_r   <= 1'b0;
            out_draw_r   <= 1'b0;
            busy_r       <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (pop_s) begin
                        out_x_r      <= head_s.x;
                        out_y_r      <= head_s.y;
                        out_colour_r <= head_s.colour;
                        out_full_r   <= head_s.full;
                        out_draw_r   <= 1'b1;
                        cnt_r        <= load_s;
                        busy_r       <= 1'b1;
                        state_r      <= ST_ISSUE;
                    end else begin
                        out_draw_r   <= 1'b0;
                        busy_r       <= 1'b0;
                        state_r      <= ST_IDLE;
                    end
                end
                ST_ISSUE: begin
                    out_draw_r <= 1'b0;
                    busy_r     <= 1'b1;
                    state_r    <= ST_WAIT;
                    if (cnt_r != {CNT_W{1'b0}}) begin
                        cnt_r <= cnt_r - CNT_W'(1);
                    end else begin
                        cnt_r <= {CNT_W{1'b0}};
                    end
                end
                ST_WAIT: begin
                    out_draw_r <= 1'b0;
                    // Leave on the edge where the counter reaches zero; a
                    // zero count also exits so the counter never wraps
                    if (cnt_r <= CNT_W'(1)) begin
                        cnt_r   <= {CNT_W{1'b0}};
                        busy_r  <= 1'b0;
                        state_r <= ST_IDLE;
                    end else begin
                        cnt_r   <= cnt_r - CNT_W'(1);
                        busy_r  <= 1'b1;
                        state_r <= ST_WAIT;
                    end
                end
                default: begin
                    cnt_r      <= {CNT_W{1'b0}};
                    out_draw_r <= 1'b0;
                    busy_r     <= 1'b0;
                    state_r    <= ST_IDLE;
                end
            endcase
        end
    end

    assign in_ready   = ~fifo_full_s;
    assign out_x      = out_x_r;
    assign out_y      = out_y_r;
    assign out_colour = out_colour_r;
    assign out_full   = out_full_r;
    assign out_draw   = out_draw_r;
    assign busy       = busy_r;

endmodule

// File: tb/tb_draw_cmd_queue.sv
// ---------------------------------------------------------------------------
// tb_draw_cmd_queue
// Self-checking bench for draw_cmd_queue with DEPTH=4, BOX_CYCLES=4,
// FULL_CYCLES=10. A cycle-by-cycle vector table covers single and
// back-to-back issue; hand-written sequences cover back-pressure, full-box
// pacing, asynchronous reset mid-interval and full-command coalescing.
// ---------------------------------------------------------------------------
module tb_draw_cmd_queue;

    localparam int DEPTH = 4;
    localparam int BOX   = 4;
    localparam int FULL  = 10;
    localparam int CNT_W = 15;

    logic       clock = 1'b0;
    logic       resetn = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] in_x = 8'd0;
    logic [7:0] in_y = 8'd0;
    logic [2:0] in_colour = 3'd0;
    logic       in_full = 1'b0;
    logic [7:0] out_x;
    logic [7:0] out_y;
    logic [2:0] out_colour;
    logic       out_full;
    logic       out_draw;
    logic       busy;
    logic [2:0] level;

    int tests = 0;
    int fails = 0;

    draw_cmd_queue #(
        .DEPTH       (DEPTH),
        .BOX_CYCLES  (BOX),
        .FULL_CYCLES (FULL),
        .CNT_W       (CNT_W)
    ) dut (
        .clock      (clock),
        .resetn     (resetn),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_x       (in_x),
        .in_y       (in_y),
        .in_colour  (in_colour),
        .in_full    (in_full),
        .out_x      (out_x),
        .out_y      (out_y),
        .out_colour (out_colour),
        .out_full   (out_full),
        .out_draw   (out_draw),
        .busy       (busy),
        .level      (level)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic       v;
        logic [7:0] x;
        logic [7:0] y;
        logic [2:0] c;
        logic       f;
        logic       er;
        logic [2:0] el;
        logic       ed;
        logic       eb;
        logic       co;
        logic [7:0] ex;
        logic [7:0] ey;
        logic [2:0] ec;
        logic       ef;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic v, input int x, input int y, input int c,
                                input logic f, input logic er, input int el,
                                input logic ed, input logic eb, input logic co,
                                input int ex, input int ey, input int ec, input logic ef);
        vec_t r;
        r.v = v; r.x = x[7:0]; r.y = y[7:0]; r.c = c[2:0]; r.f = f;
        r.er = er; r.el = el[2:0]; r.ed = ed; r.eb = eb; r.co = co;
        r.ex = ex[7:0]; r.ey = ey[7:0]; r.ec = ec[2:0]; r.ef = ef;
        return r;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic v, input int x, input int y, input int c, input logic f);
        in_valid  = v;
        in_x      = x[7:0];
        in_y      = y[7:0];
        in_colour = c[2:0];
        in_full   = f;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((busy || level != 3'd0) && n < 100) begin
            tick();
            n++;
        end
        chk("wait_idle_bound", int'(n < 100), 1);
    endtask

    // Waits for the next out_draw, returns edges waited; expiry counts as a failure
    task automatic wait_draw(input int max, output int waited);
        waited = 0;
        do begin
            tick();
            waited++;
        end while (!out_draw && waited < max);
        chk("wait_draw_bound", int'(out_draw), 1);
    endtask

    initial begin
        int n, busy_n, gap, draws, k, blocked;
        logic rdy_prev;
        logic [7:0] exp_q[$];
        logic [7:0] bp_x[7];

        // --- vector table: {v,x,y,c,f | ready,level,draw,busy,chk_out,x,y,c,full}
        // single push at edge 0
        vecs.push_back(mk(1, 5, 7, 4, 0,  1, 1, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0,  1, 0, 1, 1, 1, 5, 7, 4, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0,  1, 0, 0, 1, 1, 5, 7, 4, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0,  1, 0, 0, 1, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0,  1, 0, 0, 1, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0,  1, 0, 0, 0, 1, 5, 7, 4, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0, 0, 0, 0));
        // three pushes on consecutive edges: draws after edges 1, 6, 11
        vecs.push_back(mk(1, 1, 10, 1, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 2, 11, 2, 0, 1, 1, 1, 1, 1, 1, 10, 1, 0));
        vecs.push_back(mk(1, 3, 12, 3, 0, 1, 2, 0, 1, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0,  1, 2, 0, 1, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0,  1, 2, 0, 1, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0,  1, 2, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0,  1, 1, 1, 1, 1, 2, 11, 2, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0,  1, 1, 0, 1, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0,  1, 1, 0, 1, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0,  1, 1, 0, 1, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0,  1, 1, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0,  1, 0, 1, 1, 1, 3, 12, 3, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0,  1, 0, 0, 1, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0,  1, 0, 0, 1, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0,  1, 0, 0, 1, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0,  1, 0, 0, 0, 1, 3, 12, 3, 0));

        // --- reset state
        repeat (2) @(posedge clock);
        #1;
        chk("rst_level", int'(level), 0);
        chk("rst_ready", int'(in_ready), 1);
        chk("rst_busy", int'(busy), 0);
        chk("rst_draw", int'(out_draw), 0);
        chk("rst_out_x", int'(out_x), 0);
        chk("rst_out_colour", int'(out_colour), 0);
        @(negedge clock);
        resetn = 1'b1;

        // --- table-driven single and back-to-back issue
        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].v, int'(vecs[i].x), int'(vecs[i].y), int'(vecs[i].c), vecs[i].f);
            tick();
            chk($sformatf("vec%0d_ready", i), int'(in_ready), int'(vecs[i].er));
            chk($sformatf("vec%0d_level", i), int'(level), int'(vecs[i].el));
            chk($sformatf("vec%0d_draw", i), int'(out_draw), int'(vecs[i].ed));
            chk($sformatf("vec%0d_busy", i), int'(busy), int'(vecs[i].eb));
            if (vecs[i].co) begin
                chk($sformatf("vec%0d_out_x", i), int'(out_x), int'(vecs[i].ex));
                chk($sformatf("vec%0d_out_y", i), int'(out_y), int'(vecs[i].ey));
                chk($sformatf("vec%0d_out_colour", i), int'(out_colour), int'(vecs[i].ec));
                chk($sformatf("vec%0d_out_full", i), int'(out_full), int'(vecs[i].ef));
            end
        end
        drive(0, 0, 0, 0, 0);

        // --- full command pacing: F then small S, next draw 11 edges after F
        drive(1, 50, 1, 7, 1);
        tick();
        drive(1, 51, 2, 2, 0);
        tick();
        drive(0, 0, 0, 0, 0);
        chk("full_draw", int'(out_draw), 1);
        chk("full_out_full", int'(out_full), 1);
        chk("full_out_colour", int'(out_colour), 7);
        busy_n = int'(busy);
        gap = 0;
        for (int t = 1; t <= 40; t++) begin
            tick();
            if (out_draw) begin
                gap = t;
                break;
            end
            if (busy) busy_n++;
        end
        chk("full_busy_cycles", busy_n, FULL);
        chk("full_draw_gap", gap, FULL + 1);
        chk("full_next_x", int'(out_x), 51);
        wait_idle();

        // --- back-pressure: full command then six held small pushes
        bp_x[0] = 8'd200;
        for (int i = 1; i < 7; i++) bp_x[i] = 8'(20 + i);
        k = 0; draws = 0; blocked = 0; n = 0;
        drive(1, int'(bp_x[0]), 0, 5, 1);
        rdy_prev = in_ready;
        while (!(k == 7 && draws == 7) && n < 300) begin
            tick();
            n++;
            if (out_draw) begin
                if (exp_q.size() == 0) begin
                    chk("bp_extra_draw", int'(out_x), -1);
                end else begin
                    chk("bp_draw_order", int'(out_x), int'(exp_q.pop_front()));
                end
                draws++;
            end
            if (in_valid && rdy_prev) begin
                exp_q.push_back(in_x);
                k++;
            end
            if (level == 3'd4 && blocked == 0) begin
                blocked = 1;
                chk("bp_ready_at_full", int'(in_ready), 0);
            end
            if (k < 7) drive(1, int'(bp_x[k]), 0, 1, 0);
            else drive(0, 0, 0, 0, 0);
            rdy_prev = in_ready;
        end
        chk("bp_accepted", k, 7);
        chk("bp_draws", draws, 7);
        chk("bp_blocked_seen", blocked, 1);
        draws = 0;
        repeat (12) begin
            tick();
            if (out_draw) draws++;
        end
        chk("bp_no_extra_draw", draws, 0);
        wait_idle();

        // --- asynchronous reset in WAIT with level=3
        drive(1, 60, 0, 1, 1);
        tick();
        drive(1, 61, 0, 1, 0);
        tick();
        drive(1, 62, 0, 1, 0);
        tick();
        drive(1, 63, 0, 1, 0);
        tick();
        drive(0, 0, 0, 0, 0);
        tick();
        tick();
        chk("rstw_pre_level", int'(level), 3);
        chk("rstw_pre_busy", int'(busy), 1);
        #2;
        resetn = 1'b0;
        #1;
        chk("rstw_level", int'(level), 0);
        chk("rstw_ready", int'(in_ready), 1);
        chk("rstw_busy", int'(busy), 0);
        chk("rstw_draw", int'(out_draw), 0);
        chk("rstw_out_x", int'(out_x), 0);
        chk("rstw_out_full", int'(out_full), 0);
        @(negedge clock);
        @(negedge clock);
        resetn = 1'b1;
        draws = 0;
        repeat (30) begin
            tick();
            if (out_draw) draws++;
        end
        chk("rstw_no_draw", draws, 0);

        // --- full command pushed behind three queued small commands
        drive(1, 70, 0, 1, 1);
        tick();
        drive(1, 71, 0, 1, 0);
        tick();
        drive(1, 72, 0, 1, 0);
        tick();
        drive(1, 73, 0, 1, 0);
        tick();
        chk("coal_pre_level", int'(level), 3);
        drive(1, 79, 0, 5, 1);
        tick();
        drive(0, 0, 0, 0, 0);
`ifdef DRAW_QUEUE_COALESCE_EN
        chk("coal_level", int'(level), 1);
        wait_draw(40, n);
        chk("coal_next_x", int'(out_x), 79);
        chk("coal_next_full", int'(out_full), 1);
`else
        chk("coal_level", int'(level), 4);
        wait_draw(40, n);
        chk("coal_next_x", int'(out_x), 71);
        chk("coal_next_full", int'(out_full), 0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
